mem_access: RTL

- Memory-access stage directly downstream of the ALU in the RockWave core.
- Consumes the ALU result (aluout) as either a pass-through result or a load/store effective address.
- Runs the data-bus request/acknowledge handshake for RV32I byte, halfword and word accesses, including byte-lane alignment and sign/zero extension.
- Delivers one registered writeback pulse per accepted operation.

---
 rtl/mem_access.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access stage that sits directly after the ALU.
//
// The stage takes an ALU result and does one of three things with it:
//   - Non-memory op: the result goes to writeback one cycle later.
//   - Faulting memory op (illegal funct3 or misaligned halfword/word):
//     no bus cycle is issued. Writeback happens one cycle later with
//     misalign=1 and the faulting address.
//   - Legal load/store: a single data-bus request is held until d_ack.
//     Writeback then carries either the extended load data or, for a
//     store, a zero result.
//
// Ports:
//   clk, rst            core clock (rising edge), async active-high reset
//   ex_valid/ex_ready   operation handshake from the execute stage
//   aluout              ALU result or effective address
//   rs2_data            store data
//   funct3              RV32I load/store width code
//   is_load/is_store    operation class (is_load wins if both are set)
//   rd_addr             destination register
//   d_req/d_we/d_addr/d_be/d_wdata   data-bus request, held stable until d_ack
//   d_ack/d_rdata       bus completion and read data
//   wb_valid            one-cycle writeback pulse
//   wb_data/wb_rd       writeback value and destination, held between pulses
//   misalign            access fault flag, qualified by wb_valid

module mem_access #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [XLEN-1:0] aluout,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [2:0]      funct3,
   input  logic            is_load,
   input  logic            is_store,
   input  logic [4:0]      rd_addr,
   output logic            d_req,
   output logic            d_we,
   output logic [XLEN-1:0] d_addr,
   output logic [3:0]      d_be,
   output logic [XLEN-1:0] d_wdata,
   input  logic            d_ack,
   input  logic [XLEN-1:0] d_rdata,
   output logic            wb_valid,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wb_rd,
   output logic            misalign
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e state_q, state_d;

   logic            d_req_q,    d_req_d;
   logic            d_we_q,     d_we_d;
   logic [XLEN-1:0] d_addr_q,   d_addr_d;
   logic [3:0]      d_be_q,     d_be_d;
   logic [XLEN-1:0] d_wdata_q,  d_wdata_d;
   logic            wb_valid_q, wb_valid_d;
   logic [XLEN-1:0] wb_data_q,  wb_data_d;
   logic [4:0]      wb_rd_q,    wb_rd_d;
   logic            misalign_q, misalign_d;
   // Per-transaction context kept for the load-result formatting.
   logic [1:0]      off_q,      off_d;
   logic [2:0]      f3_q,       f3_d;
   logic [4:0]      rd_q,       rd_d;

   logic            accept;
   logic            is_mem;
   logic            store_op;
   logic            f3_legal;
   logic            misaligned;
   logic            fault;
   logic [3:0]      lane_be;
   logic [XLEN-1:0] lane_wdata;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] load_data;

   assign ex_ready = (state_q == StIdle);
   assign accept   = ex_valid && ex_ready;

   // ------------------------------------------------------------------
   // Decode of the incoming operation
   // ------------------------------------------------------------------
   always_comb begin
      is_mem     = is_load || is_store;
      store_op   = is_store && !is_load;
      f3_legal   = 1'b0;
      if (is_load) begin
         unique case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default:                                f3_legal = 1'b0;
         endcase
      end else begin
         unique case (funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            default:                f3_legal = 1'b0;
         endcase
      end
      misaligned = ((funct3[1:0] == 2'b01) && aluout[0]) ||
                   ((funct3[1:0] == 2'b10) && (aluout[1:0] != 2'b00));
      fault      = is_mem && (!f3_legal || misaligned);
   end

   // Byte-lane enables and lane-replicated store data. Loads use the same
   // enables so the bus can see which lanes are actually consumed.
   always_comb begin
      lane_be    = 4'b1111;
      lane_wdata = rs2_data;
      case (funct3[1:0])
         2'b00: begin
            lane_be    = 4'b0001 << aluout[1:0];
            lane_wdata = {4{rs2_data[7:0]}};
         end
         2'b01: begin
            lane_be    = aluout[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{rs2_data[15:0]}};
         end
         default: begin
            lane_be    = 4'b1111;
            lane_wdata = rs2_data;
         end
      endcase
      if (!store_op) begin
         lane_wdata = '0;
      end
   end

   // ------------------------------------------------------------------
   // Load result formatting from the latched offset and width
   // ------------------------------------------------------------------
   always_comb begin
      unique case (off_q)
         2'd0:    ld_byte = d_rdata[7:0];
         2'd1:    ld_byte = d_rdata[15:8];
         2'd2:    ld_byte = d_rdata[23:16];
         default: ld_byte = d_rdata[31:24];
      endcase
      ld_half = off_q[1] ? d_rdata[31:16] : d_rdata[15:0];
      unique case (f3_q)
         3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_data = {24'b0, ld_byte};
         3'b101:  load_data = {16'b0, ld_half};
         default: load_data = d_rdata;
      endcase
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      d_req_d    = d_req_q;
      d_we_d     = d_we_q;
      d_addr_d   = d_addr_q;
      d_be_d     = d_be_q;
      d_wdata_d  = d_wdata_q;
      wb_valid_d = 1'b0;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      misalign_d = misalign_q;
      off_d      = off_q;
      f3_d       = f3_q;
      rd_d       = rd_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (!is_mem) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = aluout;
                  wb_rd_d    = rd_addr;
                  misalign_d = 1'b0;
               end else if (fault) begin
                  // Report the faulting address; nothing reaches the bus.
                  wb_valid_d = 1'b1;
                  wb_data_d  = aluout;
                  wb_rd_d    = 5'd0;
                  misalign_d = 1'b1;
               end else begin
                  state_d   = StBusy;
                  d_req_d   = 1'b1;
                  d_we_d    = store_op;
                  d_addr_d  = {aluout[XLEN-1:2], 2'b00};
                  d_be_d    = lane_be;
                  d_wdata_d = lane_wdata;
                  off_d     = aluout[1:0];
                  f3_d      = funct3;
                  rd_d      = rd_addr;
               end
            end
         end
         StBusy: begin
            if (d_ack) begin
               state_d    = StIdle;
               d_req_d    = 1'b0;
               d_we_d     = 1'b0;
               d_addr_d   = '0;
               d_be_d     = 4'b0000;
               d_wdata_d  = '0;
               wb_valid_d = 1'b1;
               misalign_d = 1'b0;
               if (d_we_q) begin
                  wb_data_d = '0;
                  wb_rd_d   = 5'd0;
               end else begin
                  wb_data_d = load_data;
                  wb_rd_d   = rd_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         d_req_q    <= 1'b0;
         d_we_q     <= 1'b0;
         d_addr_q   <= '0;
         d_be_q     <= 4'b0000;
         d_wdata_q  <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= 5'd0;
         misalign_q <= 1'b0;
         off_q      <= 2'd0;
         f3_q       <= 3'd0;
         rd_q       <= 5'd0;
      end else begin
         state_q    <= state_d;
         d_req_q    <= d_req_d;
         d_we_q     <= d_we_d;
         d_addr_q   <= d_addr_d;
         d_be_q     <= d_be_d;
         d_wdata_q  <= d_wdata_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         misalign_q <= misalign_d;
         off_q      <= off_d;
         f3_q       <= f3_d;
         rd_q       <= rd_d;
      end
   end

   assign d_req    = d_req_q;
   assign d_we     = d_we_q;
   assign d_addr   = d_addr_q;
   assign d_be     = d_be_q;
   assign d_wdata  = d_wdata_q;
   assign wb_valid = wb_valid_q;
   assign wb_data  = wb_data_q;
   assign wb_rd    = wb_rd_q;
   assign misalign = misalign_q;

endmodule
